// File: rtl/clock_tick_monitor_10hz_pkg.sv
// Shared constants and types for the 10 Hz clock tick monitor.
// The defaults are tied to the 1 MHz -> 10 Hz divider it sits behind.
package clock_tick_monitor_10hz_pkg;

   // Divide factor of the upstream divider: one slow period in fast cycles
   localparam int DIVIDE_FACTOR   = 100000;

   localparam int NOMINAL_DEFAULT = DIVIDE_FACTOR;
   localparam int TOL_DEFAULT     = 100;
   // One and a half nominal periods without an edge means the clock is gone
   localparam int TIMEOUT_DEFAULT = (DIVIDE_FACTOR * 3) / 2;
   // 2^18 = 262144 comfortably holds the timeout value
   localparam int CNT_W_DEFAULT   = 18;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      FAULT   = 2'd2
   } monitorState_e;

   // Fault counter increments stick at all-ones instead of wrapping
   function automatic logic [7:0] satIncrement8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/clock_tick_monitor_10hz_sync_edge_detect.sv
// Two-flop synchronizer plus a history flop, producing a single-cycle
// rising-edge strobe for an asynchronous input. Flops reset to RESET_VAL
// so an input already sitting at that level gives no edge at release.
module clock_tick_monitor_10hz_sync_edge_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic data_i,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Synchronize the async input and keep one cycle of history for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= RESET_VAL;
         sync2_q <= RESET_VAL;
         prev_q  <= RESET_VAL;
      end else begin
         sync1_q <= data_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/clock_tick_monitor_10hz.sv
// Monitors a slow (10 Hz) clock from the 1 MHz domain: emits a one-cycle
// tick per rising edge, measures each period in fast cycles, and flags a
// fault when the slow clock stops or drifts outside the tolerance window.
module clock_tick_monitor_10hz
   import clock_tick_monitor_10hz_pkg::*;
#(
   parameter int NOMINAL = NOMINAL_DEFAULT,
   parameter int TOL     = TOL_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
) (
   input  logic             CLK_1MHZ_IN,
   input  logic             RESET,
   input  logic             CLK_10HZ_IN,
   output logic             TICK_RISE,
   output logic [CNT_W-1:0] PERIOD_COUNT,
   output logic             PERIOD_VALID,
   output logic             CLK_FAULT,
   output logic [7:0]       FAULT_COUNT
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LOW_C     = CNT_W'(NOMINAL - TOL);
   localparam logic [CNT_W-1:0] HIGH_C    = CNT_W'(NOMINAL + TOL);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic             riseDet;
   logic             atTimeout;
   logic             inTolerance;
   logic [CNT_W-1:0] cntInc_d;
   logic [7:0]       faultInc_d;

   monitorState_e    state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             tickRise_q;
   logic [CNT_W-1:0] periodCount_q;
   logic             periodValid_q;
   logic             clkFault_q;
   logic [7:0]       faultCount_q;

   clock_tick_monitor_10hz_sync_edge_detect #(
      .RESET_VAL (1'b1)
   ) u_syncEdge (
      .clk_i  (CLK_1MHZ_IN),
      .rst_ni (RESET),
      .data_i (CLK_10HZ_IN),
      .rise_o (riseDet)
   );

   // Saturating next values for the period counter and the fault counter
   always_comb begin
      atTimeout   = (cnt_q == TIMEOUT_C);
      inTolerance = (cnt_q >= LOW_C) && (cnt_q <= HIGH_C);
      cntInc_d    = atTimeout ? cnt_q : (cnt_q + ONE_C);
      faultInc_d  = satIncrement8(faultCount_q);
   end

   // Monitor FSM: tick, period counter, measurement and fault reporting.
   // An edge always takes priority over a timeout landing on the same cycle.
   always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
      if (!RESET) begin
         state_q       <= IDLE;
         cnt_q         <= ONE_C;
         tickRise_q    <= 1'b0;
         periodCount_q <= '0;
         periodValid_q <= 1'b0;
         clkFault_q    <= 1'b0;
         faultCount_q  <= 8'd0;
      end else begin
         tickRise_q <= riseDet;
         cnt_q      <= riseDet ? ONE_C : cntInc_d;

         case (state_q)
            IDLE: begin
               if (riseDet) begin
                  state_q <= MEASURE;
               end else if (atTimeout) begin
                  state_q       <= FAULT;
                  clkFault_q    <= 1'b1;
                  periodValid_q <= 1'b0;
                  faultCount_q  <= faultInc_d;
               end
            end

            MEASURE: begin
               if (riseDet) begin
                  periodCount_q <= cnt_q;
                  periodValid_q <= 1'b1;
                  if (inTolerance) begin
                     clkFault_q <= 1'b0;
                  end else begin
                     clkFault_q   <= 1'b1;
                     faultCount_q <= faultInc_d;
                  end
               end else if (atTimeout) begin
                  state_q       <= FAULT;
                  clkFault_q    <= 1'b1;
                  periodValid_q <= 1'b0;
                  faultCount_q  <= faultInc_d;
               end
            end

            FAULT: begin
               if (riseDet) begin
                  state_q <= MEASURE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign TICK_RISE    = tickRise_q;
   assign PERIOD_COUNT = periodCount_q;
   assign PERIOD_VALID = periodValid_q;
   assign CLK_FAULT    = clkFault_q;
   assign FAULT_COUNT  = faultCount_q;

endmodule

// File: tb/tb_clock_tick_monitor_10hz.sv
// Directed bench for the 10 Hz clock tick monitor, run with scaled-down
// parameters (nominal 100 cycles, tolerance 5, timeout 150).
module tb_clock_tick_monitor_10hz;

   localparam int NOMINAL = 100;
   localparam int TOL     = 5;
   localparam int TIMEOUT = 150;
   localparam int CNT_W   = 8;

   logic             clock;
   logic             resetN;
   logic             slowClock;
   logic             tickRise;
   logic [CNT_W-1:0] periodCount;
   logic             periodValid;
   logic             clkFault;
   logic [7:0]       faultCount;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   clock_tick_monitor_10hz #(
      .NOMINAL (NOMINAL),
      .TOL     (TOL),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .CLK_1MHZ_IN  (clock),
      .RESET        (resetN),
      .CLK_10HZ_IN  (slowClock),
      .TICK_RISE    (tickRise),
      .PERIOD_COUNT (periodCount),
      .PERIOD_VALID (periodValid),
      .CLK_FAULT    (clkFault),
      .FAULT_COUNT  (faultCount)
   );

   // Fast clock, 10 time units per cycle
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog so the run always terminates
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
      end
      #1;
   endtask

   // Drive the slow clock to a level and let n fast cycles pass
   task automatic applyStimulus(input logic level, input int n);
      slowClock = level;
      waitCycles(n);
   endtask

   // Complete a slow period of n cycles whose rising edge happened 'used' cycles ago
   task automatic finishPeriod(input int n, input int used);
      waitCycles(n / 2 - used);
      applyStimulus(1'b0, n - n / 2);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " tick"},   32'(tickRise),    32'd0);
      checkOutput({tag, " period"}, 32'(periodCount), 32'd0);
      checkOutput({tag, " valid"},  32'(periodValid), 32'd0);
      checkOutput({tag, " fault"},  32'(clkFault),    32'd0);
      checkOutput({tag, " fcount"}, 32'(faultCount),  32'd0);
   endtask

   initial begin
      int expCount;
      resetN    = 1'b1;
      slowClock = 1'b1;
      #2;
      resetN = 1'b0;
      waitCycles(3);
      checkAllZero("reset");

      // Release with slow clock high: no tick, then one tick 3 cycles after the rise
      resetN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         waitCycles(1);
         checkOutput("release high no tick", 32'(tickRise), 32'd0);
      end
      applyStimulus(1'b0, 5);
      applyStimulus(1'b1, 2);
      checkOutput("tick not early", 32'(tickRise), 32'd0);
      waitCycles(1);
      checkOutput("first rise tick", 32'(tickRise), 32'd1);
      checkOutput("first rise no period", 32'(periodValid), 32'd0);
      checkOutput("first rise period 0", 32'(periodCount), 32'd0);
      waitCycles(1);
      checkOutput("tick one cycle", 32'(tickRise), 32'd0);
      finishPeriod(100, 4);

      // Nominal period
      applyStimulus(1'b1, 3);
      checkOutput("nominal tick", 32'(tickRise), 32'd1);
      checkOutput("nominal period", 32'(periodCount), 32'd100);
      checkOutput("nominal valid", 32'(periodValid), 32'd1);
      checkOutput("nominal fault", 32'(clkFault), 32'd0);
      checkOutput("nominal fcount", 32'(faultCount), 32'd0);
      finishPeriod(95, 3);

      // Lower tolerance boundary is accepted
      applyStimulus(1'b1, 3);
      checkOutput("low bound period", 32'(periodCount), 32'd95);
      checkOutput("low bound fault", 32'(clkFault), 32'd0);
      finishPeriod(106, 3);

      // One past the upper boundary is a fault
      applyStimulus(1'b1, 3);
      checkOutput("slow period", 32'(periodCount), 32'd106);
      checkOutput("slow fault", 32'(clkFault), 32'd1);
      checkOutput("slow fcount", 32'(faultCount), 32'd1);
      checkOutput("slow valid", 32'(periodValid), 32'd1);
      finishPeriod(105, 3);

      // Upper boundary is accepted and clears the fault
      applyStimulus(1'b1, 3);
      checkOutput("high bound period", 32'(periodCount), 32'd105);
      checkOutput("high bound fault", 32'(clkFault), 32'd0);
      checkOutput("high bound fcount", 32'(faultCount), 32'd1);

      // Slow clock stops: timeout exactly 150 cycles after the last rise
      waitCycles(10);
      applyStimulus(1'b0, 139);
      checkOutput("pre timeout fault", 32'(clkFault), 32'd0);
      checkOutput("pre timeout valid", 32'(periodValid), 32'd1);
      waitCycles(1);
      checkOutput("timeout fault", 32'(clkFault), 32'd1);
      checkOutput("timeout valid", 32'(periodValid), 32'd0);
      checkOutput("timeout fcount", 32'(faultCount), 32'd2);
      checkOutput("timeout period held", 32'(periodCount), 32'd105);
      waitCycles(20);
      checkOutput("timeout counted once", 32'(faultCount), 32'd2);

      // Resume: first rise records nothing, second clears the fault
      applyStimulus(1'b1, 3);
      checkOutput("resume tick", 32'(tickRise), 32'd1);
      checkOutput("resume no period", 32'(periodCount), 32'd105);
      checkOutput("resume no valid", 32'(periodValid), 32'd0);
      checkOutput("resume still fault", 32'(clkFault), 32'd1);
      finishPeriod(100, 3);
      applyStimulus(1'b1, 3);
      checkOutput("recovered period", 32'(periodCount), 32'd100);
      checkOutput("recovered valid", 32'(periodValid), 32'd1);
      checkOutput("recovered fault", 32'(clkFault), 32'd0);
      checkOutput("recovered fcount", 32'(faultCount), 32'd2);
      finishPeriod(150, 3);

      // Edge lands on the timeout cycle: recorded as an out-of-tolerance period
      applyStimulus(1'b1, 3);
      checkOutput("edge at timeout period", 32'(periodCount), 32'd150);
      checkOutput("edge at timeout fault", 32'(clkFault), 32'd1);
      checkOutput("edge at timeout valid", 32'(periodValid), 32'd1);
      checkOutput("edge at timeout fcount", 32'(faultCount), 32'd3);
      finishPeriod(100, 3);
      applyStimulus(1'b1, 3);
      checkOutput("still measuring period", 32'(periodCount), 32'd100);
      checkOutput("still measuring fault", 32'(clkFault), 32'd0);
      checkOutput("still measuring fcount", 32'(faultCount), 32'd3);

      // Asynchronous reset between clock edges, release with input high
      waitCycles(20);
      #2;
      resetN = 1'b0;
      #1;
      checkAllZero("async reset");
      waitCycles(2);
      resetN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         waitCycles(1);
         checkOutput("release high spurious tick", 32'(tickRise), 32'd0);
      end

      // Reset again, release with input low
      #2;
      resetN    = 1'b0;
      slowClock = 1'b0;
      waitCycles(2);
      resetN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         waitCycles(1);
         checkOutput("release low spurious tick", 32'(tickRise), 32'd0);
      end

      // 300 fast periods: fault count saturates, ticks keep coming
      applyStimulus(1'b1, 3);
      checkOutput("sat first tick", 32'(tickRise), 32'd1);
      checkOutput("sat first fcount", 32'(faultCount), 32'd0);
      finishPeriod(50, 3);
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 3);
         expCount = (i + 1 > 255) ? 255 : i + 1;
         checkOutput("sat tick", 32'(tickRise), 32'd1);
         checkOutput("sat fcount", 32'(faultCount), 32'(expCount));
         finishPeriod(50, 3);
      end
      checkOutput("sat final fcount", 32'(faultCount), 32'd255);
      checkOutput("sat final period", 32'(periodCount), 32'd50);
      checkOutput("sat final fault", 32'(clkFault), 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
